// File: rtl/ifetch_prefetch_queue.sv
// Instruction-fetch prefetcher: credit-limited sequential fetch into an in-order FIFO feeding IF/ID.
// A redirect flushes buffered entries and drops every response still owed by the memory.
module ifetch_prefetch_queue #(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_instr,
    output logic [ADDR_W-1:0] id_pc
);
    localparam int unsigned   PW      = $clog2(DEPTH);
    localparam int unsigned   CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       instr;
    } entry_t;

    entry_t            entries [DEPTH];
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic [CW-1:0]     count;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     drop;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    logic [CW:0]       credits_used;
    logic              req_fire;
    logic              rsp_accept;
    logic              push;
    logic              pop;
    logic [CW-1:0]     inflight_next;

    // NOTE: every signal below is assigned on every path through the block, so nothing here can become a latch.
    always_comb begin
        credits_used   = {1'b0, count} + {1'b0, inflight};
        imem_req_valid = !reset && !redirect && (credits_used < DEPTH_C);
        imem_req_addr  = fetch_pc;
        req_fire       = imem_req_valid && imem_req_ready;
        // A response with nothing outstanding is a protocol error and is ignored entirely.
        rsp_accept     = imem_rsp_valid && (inflight != '0);
        push           = rsp_accept && (drop == '0) && !redirect;
        id_valid       = (count != '0) && !redirect;
        pop            = id_valid && id_ready;
        id_instr       = id_valid ? entries[rd_ptr].instr : '0;
        id_pc          = id_valid ? entries[rd_ptr].pc : '0;
        inflight_next  = inflight + CW'(req_fire) - CW'(rsp_accept);
    end

    // NOTE: state uses non-blocking assignments so every register sees pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            // NOTE: the entry array is cleared with the control state so no X can ever reach IF/ID.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            inflight <= inflight_next;
            if (redirect) begin
                // Everything still owed by the memory belongs to the old path.
                fetch_pc <= redirect_pc;
                rsp_pc   <= redirect_pc;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                drop     <= inflight_next;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + ADDR_W'(4);
                end
                if (rsp_accept && (drop != '0)) begin
                    drop <= drop - 1'b1;
                end
                if (push) begin
                    entries[wr_ptr] <= '{pc: rsp_pc, instr: imem_rsp_data};
                    wr_ptr          <= wr_ptr + 1'b1;
                    rsp_pc          <= rsp_pc + ADDR_W'(4);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Bench for ifetch_prefetch_queue: fixed-latency memory model, queue-based reference model
// compared every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_ifetch_prefetch_queue;
    localparam int          DEPTH    = 4;
    localparam int          ADDR_W   = 64;
    localparam logic [63:0] RESET_PC = 64'h0;
    localparam int          MAX_CYC  = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [63:0] id_pc;

    always #5 clk = ~clk;

    ifetch_prefetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc)
    );

    // Memory: answers each accepted request mem_lat cycles later, in order.
    typedef struct { int due; logic [63:0] addr; } mem_req_t;
    mem_req_t mem_q[$];
    int       mem_lat = 1;

    // Reference model state, kept as plain queues and integers.
    typedef struct { logic [63:0] pc; logic [31:0] instr; } entry_t;
    entry_t      m_fifo[$];
    logic [63:0] m_fetch_pc;
    logic [63:0] m_rsp_pc;
    int          m_inflight;
    int          m_drop;

    int cyc     = 0;
    int n_checks = 0;
    int n_fail   = 0;

    logic        obs_req_valid [MAX_CYC];
    logic        obs_fire      [MAX_CYC];
    logic [63:0] obs_addr      [MAX_CYC];
    logic        obs_id_valid  [MAX_CYC];
    logic [63:0] obs_id_pc     [MAX_CYC];
    logic [31:0] obs_id_instr  [MAX_CYC];

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_fetch_pc = RESET_PC;
        m_rsp_pc   = RESET_PC;
        m_inflight = 0;
        m_drop     = 0;
    endtask

    // One clock cycle: drive memory response, compare at negedge, advance model and memory.
    task automatic step();
        logic        exp_req_valid;
        logic        exp_id_valid;
        logic [63:0] exp_addr;
        logic [63:0] exp_id_pc;
        logic [31:0] exp_id_instr;
        logic        fire;
        logic        rsp;
        if (!reset && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(mem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        @(negedge clk);
        if (reset) begin
            exp_req_valid = 1'b0;
            exp_addr      = RESET_PC;
            exp_id_valid  = 1'b0;
            exp_id_pc     = 64'h0;
            exp_id_instr  = 32'h0;
        end else begin
            exp_req_valid = !redirect && (m_fifo.size() + m_inflight < DEPTH);
            exp_addr      = m_fetch_pc;
            exp_id_valid  = !redirect && (m_fifo.size() != 0);
            exp_id_pc     = exp_id_valid ? m_fifo[0].pc : 64'h0;
            exp_id_instr  = exp_id_valid ? m_fifo[0].instr : 32'h0;
        end
        check("imem_req_valid", imem_req_valid, exp_req_valid);
        check("imem_req_addr", imem_req_addr, exp_addr);
        check("id_valid", id_valid, exp_id_valid);
        check("id_pc", id_pc, exp_id_pc);
        check("id_instr", id_instr, exp_id_instr);
        if (cyc < MAX_CYC) begin
            obs_req_valid[cyc] = imem_req_valid;
            obs_fire[cyc]      = imem_req_valid && imem_req_ready;
            obs_addr[cyc]      = imem_req_addr;
            obs_id_valid[cyc]  = id_valid;
            obs_id_pc[cyc]     = id_pc;
            obs_id_instr[cyc]  = id_instr;
        end
        if (reset) begin
            model_reset();
            mem_q.delete();
        end else begin
            if (imem_rsp_valid) void'(mem_q.pop_front());
            if (imem_req_valid && imem_req_ready) mem_q.push_back('{due: cyc + mem_lat, addr: imem_req_addr});
            fire = exp_req_valid && imem_req_ready;
            rsp  = imem_rsp_valid && (m_inflight > 0);
            if (redirect) begin
                m_fifo.delete();
                if (rsp) m_inflight--;
                m_drop     = m_inflight;
                m_fetch_pc = redirect_pc;
                m_rsp_pc   = redirect_pc;
            end else begin
                if (exp_id_valid && id_ready) void'(m_fifo.pop_front());
                if (rsp) begin
                    m_inflight--;
                    if (m_drop > 0) begin
                        m_drop--;
                    end else begin
                        m_fifo.push_back('{pc: m_rsp_pc, instr: imem_rsp_data});
                        m_rsp_pc += 64'd4;
                    end
                end
                if (fire) begin
                    m_fetch_pc += 64'd4;
                    m_inflight++;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int lat, input logic idr, output int t0);
        reset = 1'b1;
        repeat (2) step();
        reset          = 1'b0;
        mem_lat        = lat;
        id_ready       = idr;
        imem_req_ready = 1'b1;
        t0             = cyc;
    endtask

    initial begin
        int          t0;
        int          t1;
        int          nf;
        int          first;
        logic [63:0] pcs_a [4];
        logic [31:0] ins_a [3];
        logic [63:0] pcs_w [4];

        reset          = 1'b1;
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = 64'h0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        model_reset();

        // Reset release, 1-cycle memory, id_ready held high.
        do_reset(1, 1'b1, t0);
        check("s0_reset_req_valid", obs_req_valid[t0-1], 1'b0);
        check("s0_reset_addr", obs_addr[t0-1], 64'h0);
        repeat (8) step();
        pcs_a = '{64'h0, 64'h4, 64'h8, 64'hC};
        ins_a = '{32'hDEAD_0000, 32'hDEAD_0004, 32'hDEAD_0008};
        check("s1_first_fire", obs_fire[t0], 1'b1);
        for (int k = 0; k < 3; k++) check("s1_addr_seq", obs_addr[t0+k], pcs_a[k]);
        check("s1_no_early_valid", obs_id_valid[t0+1], 1'b0);
        for (int k = 0; k < 3; k++) begin
            check("s1_id_valid", obs_id_valid[t0+2+k], 1'b1);
            check("s1_id_pc", obs_id_pc[t0+2+k], pcs_a[k]);
            check("s1_id_instr", obs_id_instr[t0+2+k], ins_a[k]);
        end

        // Stall IF/ID for 10 cycles: exactly DEPTH requests, then release.
        do_reset(1, 1'b0, t0);
        repeat (10) step();
        nf = 0;
        for (int k = 0; k < 10; k++) nf += int'(obs_fire[t0+k]);
        check("s2_fire_count", 64'(nf), 64'd4);
        check("s2_req_valid_off", obs_req_valid[t0+9], 1'b0);
        id_ready = 1'b1;
        t1 = cyc;
        repeat (6) step();
        for (int k = 0; k < 4; k++) begin
            check("s2_drain_valid", obs_id_valid[t1+k], 1'b1);
            check("s2_drain_pc", obs_id_pc[t1+k], pcs_a[k]);
        end

        // Memory not ready for 3 cycles: address held, no advance.
        do_reset(1, 1'b1, t0);
        repeat (2) step();
        imem_req_ready = 1'b0;
        repeat (3) step();
        imem_req_ready = 1'b1;
        repeat (3) step();
        for (int k = 2; k < 5; k++) begin
            check("s3_addr_held", obs_addr[t0+k], 64'h8);
            check("s3_valid_held", obs_req_valid[t0+k], 1'b1);
        end
        check("s3_fire_after", obs_fire[t0+5], 1'b1);
        check("s3_addr_after", obs_addr[t0+5], 64'h8);
        check("s3_addr_next", obs_addr[t0+6], 64'hC);

        // Redirect to 0x100 with two requests in flight, 3-cycle memory.
        do_reset(3, 1'b1, t0);
        repeat (2) step();
        redirect    = 1'b1;
        redirect_pc = 64'h100;
        step();
        redirect = 1'b0;
        repeat (8) step();
        check("s4_two_inflight", 64'({obs_fire[t0], obs_fire[t0+1]}), 64'h3);
        check("s4_no_req_on_redirect", obs_req_valid[t0+2], 1'b0);
        check("s4_target_addr", obs_addr[t0+3], 64'h100);
        check("s4_target_fire", obs_fire[t0+3], 1'b1);
        for (int k = 3; k < 7; k++) check("s4_fifo_empty", obs_id_valid[t0+k], 1'b0);
        check("s4_target_valid", obs_id_valid[t0+7], 1'b1);
        check("s4_target_pc", obs_id_pc[t0+7], 64'h100);
        check("s4_target_instr", obs_id_instr[t0+7], 32'hDEAD_0100);

        // Redirect coinciding with a response and a would-be pop, 2-cycle memory.
        do_reset(2, 1'b1, t0);
        repeat (3) step();
        redirect    = 1'b1;
        redirect_pc = 64'h200;
        step();
        redirect = 1'b0;
        repeat (6) step();
        check("s5_no_pop_on_redirect", obs_id_valid[t0+3], 1'b0);
        check("s5_no_req_on_redirect", obs_req_valid[t0+3], 1'b0);
        check("s5_target_addr", obs_addr[t0+4], 64'h200);
        for (int k = 4; k < 7; k++) check("s5_flushed", obs_id_valid[t0+k], 1'b0);
        check("s5_target_pc", obs_id_pc[t0+7], 64'h200);
        check("s5_target_instr", obs_id_instr[t0+7], 32'hDEAD_0200);
        check("s5_next_pc", obs_id_pc[t0+8], 64'h204);

        // Back-to-back redirects (last wins) to a target that wraps the address space.
        redirect    = 1'b1;
        redirect_pc = 64'h300;
        step();
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        step();
        redirect = 1'b0;
        t1 = cyc;
        repeat (12) step();
        check("s6_last_wins_addr", obs_addr[t1], 64'hFFFF_FFFF_FFFF_FFF8);
        first = -1;
        for (int k = t1; k < t1 + 8; k++) begin
            if (first < 0 && obs_id_valid[k]) first = k;
        end
        if (first < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL s6_timeout: no id_valid within 8 cycles of redirect");
        end else begin
            pcs_w = '{64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h4};
            for (int k = 0; k < 4; k++) check("s6_wrap_pc", obs_id_pc[first+k], pcs_w[k]);
            check("s6_wrap_instr", obs_id_instr[first+2], 32'hDEAD_0000);
        end

        // Reset asserted mid-stream with entries buffered.
        mem_lat  = 1;
        id_ready = 1'b0;
        repeat (4) step();
        check("s7_buffered", obs_id_valid[cyc-1], 1'b1);
        reset = 1'b1;
        #1;
        check("s7_imm_req_valid", imem_req_valid, 1'b0);
        check("s7_imm_id_valid", id_valid, 1'b0);
        check("s7_imm_id_pc", id_pc, 64'h0);
        check("s7_imm_addr", imem_req_addr, RESET_PC);
        step();
        step();
        reset    = 1'b0;
        id_ready = 1'b1;
        t0 = cyc;
        repeat (6) step();
        check("s7_restart_addr", obs_addr[t0], 64'h0);
        check("s7_restart_fire", obs_fire[t0], 1'b1);
        check("s7_restart_pc", obs_id_pc[t0+2], 64'h0);
        check("s7_restart_instr", obs_id_instr[t0+2], 32'hDEAD_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
